// File: rtl/sd_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_pkg
// Brief   : Shared types and constants for the SD command-layer controller.
// Rev     : 1.0
// ============================================================================
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CRC       = 3'd1,
        SEND      = 3'd2,
        WAIT_RESP = 3'd3,
        ACK       = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [6:0] c_CRC7_POLY = 7'h09;

    localparam int c_INDEX_W = 6;
    localparam int c_ARG_W   = 32;
    localparam int c_RESP_W  = 38;
    localparam int c_FRAME_W = 48;
    localparam int c_HDR_W   = 40;

    localparam logic c_START_BIT    = 1'b0;
    localparam logic c_TRANSMIT_BIT = 1'b1;
    localparam logic c_END_BIT      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module  : sd_crc7
// Brief   : Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled clock.
// Rev     : 1.0
// ============================================================================
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb  = i_bit ^ r_crc[6];
    assign o_crc = r_crc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= 7'h00;
        end else if (i_clear) begin
            r_crc <= 7'h00;
        end else if (i_en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? c_CRC7_POLY : 7'h00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_master
// Brief   : SD host command layer: frame build + CRC7, PHY handshake, response wait.
// Rev     : 1.0
// ============================================================================
module sd_cmd_master
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 7
) (
    input  logic        iClock_host,
    input  logic        iReset,
    input  logic        iNew_command,
    input  logic [5:0]  iCmd_index,
    input  logic [31:0] iCmd_argument,
    input  logic        iResp_none,
    output logic        oBusy,
    output logic [47:0] oCmd_frame,
    output logic        oStrobe_out,
    input  logic        iAck_in,
    input  logic        iStrobe_in,
    input  logic [37:0] iResponse,
    output logic        oAck_out,
    output logic        oCommand_complete,
    output logic [37:0] oResponse,
    output logic        oTimeout_error,
    output logic        oIndex_error
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_new_prev;
    logic [5:0]             r_index;
    logic [31:0]            r_arg;
    logic                   r_resp_none;
    logic [5:0]             r_bit_cnt;
    logic [TIMEOUT_W-1:0]   r_tcnt;
    logic                   r_frame_vld;
    logic [37:0]            r_response;
    logic                   r_timeout_err;
    logic                   r_index_err;

    logic                   w_accept;
    logic [c_HDR_W-1:0]     w_hdr;
    logic                   w_crc_bit;
    logic                   w_crc_last;
    logic                   w_tlast;
    logic [6:0]             w_crc;

    assign w_accept   = iNew_command & ~r_new_prev & (r_state == IDLE);
    assign w_hdr      = {c_START_BIT, c_TRANSMIT_BIT, r_index, r_arg};
    assign w_crc_bit  = w_hdr[6'd39 - r_bit_cnt];
    assign w_crc_last = (r_bit_cnt == 6'd39);
    assign w_tlast    = (r_tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    sd_crc7 u_crc7 (
        .i_clk   (iClock_host),
        .i_rst   (iReset),
        .i_clear (w_accept),
        .i_en    (r_state == CRC),
        .i_bit   (w_crc_bit),
        .o_crc   (w_crc)
    );

    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = CRC;
            CRC:       if (w_crc_last) w_next = SEND;
            SEND:      if (iAck_in) w_next = r_resp_none ? DONE : WAIT_RESP;
            WAIT_RESP: begin
                // A strobe on the final timeout cycle still counts as a response.
                if (iStrobe_in)   w_next = ACK;
                else if (w_tlast) w_next = DONE;
            end
            ACK:       w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            r_new_prev    <= 1'b0;
            r_index       <= 6'd0;
            r_arg         <= 32'd0;
            r_resp_none   <= 1'b0;
            r_bit_cnt     <= 6'd0;
            r_tcnt        <= '0;
            r_frame_vld   <= 1'b0;
            r_response    <= 38'd0;
            r_timeout_err <= 1'b0;
            r_index_err   <= 1'b0;
        end else begin
            r_new_prev <= iNew_command;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_index       <= iCmd_index;
                        r_arg         <= iCmd_argument;
                        r_resp_none   <= iResp_none;
                        r_bit_cnt     <= 6'd0;
                        r_frame_vld   <= 1'b0;
                        r_response    <= 38'd0;
                        r_timeout_err <= 1'b0;
                        r_index_err   <= 1'b0;
                    end
                end
                CRC: begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (w_crc_last) r_frame_vld <= 1'b1;
                end
                SEND: begin
                    if (iAck_in) r_tcnt <= '0;
                end
                WAIT_RESP: begin
                    if (iStrobe_in) begin
                        r_response  <= iResponse;
                        r_index_err <= (iResponse[37:32] != r_index);
                    end else if (w_tlast) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TIMEOUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The CRC register stops advancing after the last header bit, so the frame stays stable in SEND.
    assign oCmd_frame        = r_frame_vld ? {w_hdr, w_crc, c_END_BIT} : 48'd0;
    assign oBusy             = (r_state != IDLE);
    assign oStrobe_out       = (r_state == SEND);
    assign oAck_out          = (r_state == ACK);
    assign oCommand_complete = (r_state == DONE);
    assign oResponse         = r_response;
    assign oTimeout_error    = r_timeout_err;
    assign oIndex_error      = r_index_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_cmd_master
// Brief   : Directed self-checking bench for sd_cmd_master.
// Rev     : 1.0
// ============================================================================
module tb_sd_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_cmd;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        resp_none;
    logic        busy;
    logic [47:0] frame;
    logic        strobe_out;
    logic        ack_in;
    logic        strobe_in;
    logic [37:0] resp_in;
    logic        ack_out;
    logic        complete;
    logic [37:0] resp_out;
    logic        tmo_err;
    logic        idx_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sd_cmd_master #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(7)) dut (
        .iClock_host       (clk),
        .iReset            (rst),
        .iNew_command      (new_cmd),
        .iCmd_index        (cmd_idx),
        .iCmd_argument     (cmd_arg),
        .iResp_none        (resp_none),
        .oBusy             (busy),
        .oCmd_frame        (frame),
        .oStrobe_out       (strobe_out),
        .iAck_in           (ack_in),
        .iStrobe_in        (strobe_in),
        .iResponse         (resp_in),
        .oAck_out          (ack_out),
        .oCommand_complete (complete),
        .oResponse         (resp_out),
        .oTimeout_error    (tmo_err),
        .oIndex_error      (idx_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request and walks the CRC phase; returns just after edge T0+40.
    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic rn, input logic hold, input logic [47:0] exp_frame);
        int early;
        cmd_idx = idx; cmd_arg = arg; resp_none = rn; new_cmd = 1'b1;
        tick();
        if (!hold) new_cmd = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL accept_busy idx=%0d got %b want 1", idx, busy); end
        early = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (strobe_out !== 1'b0) early++;
        end
        vectors++;
        if (early != 0) begin miscompares++; $display("FAIL crc_phase_strobe idx=%0d early strobes %0d want 0", idx, early); end
        tick();
        vectors++;
        if (strobe_out !== 1'b1) begin miscompares++; $display("FAIL strobe_T40 idx=%0d got %b want 1", idx, strobe_out); end
        vectors++;
        if (frame !== exp_frame) begin miscompares++; $display("FAIL frame idx=%0d got %h want %h", idx, frame, exp_frame); end
    endtask

    task automatic test_reset();
        rst = 1'b1; new_cmd = 1'b0; cmd_idx = 6'd0; cmd_arg = 32'd0; resp_none = 1'b0;
        ack_in = 1'b0; strobe_in = 1'b0; resp_in = 38'd0;
        tick(); tick();
        vectors++;
        if ({busy, strobe_out, ack_out, complete, tmo_err, idx_err} !== 6'b0) begin
            miscompares++; $display("FAIL reset_flags got %b want 000000", {busy, strobe_out, ack_out, complete, tmo_err, idx_err});
        end
        vectors++;
        if (frame !== 48'd0) begin miscompares++; $display("FAIL reset_frame got %h want 0", frame); end
        vectors++;
        if (resp_out !== 38'd0) begin miscompares++; $display("FAIL reset_resp got %h want 0", resp_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cmd0();
        start_cmd(6'd0, 32'd0, 1'b1, 1'b0, 48'h400000000095);
        tick();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        vectors++;
        if (complete !== 1'b1) begin miscompares++; $display("FAIL cmd0_complete_T42 got %b want 1", complete); end
        vectors++;
        if ({strobe_out, busy, tmo_err, idx_err} !== 4'b0100) begin
            miscompares++; $display("FAIL cmd0_status got %b want 0100", {strobe_out, busy, tmo_err, idx_err});
        end
        vectors++;
        if (resp_out !== 38'd0) begin miscompares++; $display("FAIL cmd0_resp got %h want 0", resp_out); end
        tick();
        vectors++;
        if ({complete, busy} !== 2'b00) begin miscompares++; $display("FAIL cmd0_idle got %b want 00", {complete, busy}); end
    endtask

    task automatic test_cmd8();
        int acks;
        start_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 48'h48000001AA87);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        vectors++;
        if ({strobe_out, busy} !== 2'b01) begin miscompares++; $display("FAIL cmd8_wait_entry got %b want 01", {strobe_out, busy}); end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack_out) acks++;
        end
        strobe_in = 1'b1; resp_in = {6'd8, 32'h1AA};
        tick();
        strobe_in = 1'b0; resp_in = 38'd0;
        vectors++;
        if (ack_out !== 1'b1 || acks != 0) begin miscompares++; $display("FAIL cmd8_ack got %b early %0d want 1 early 0", ack_out, acks); end
        vectors++;
        if (resp_out !== 38'h08000001AA) begin miscompares++; $display("FAIL cmd8_resp got %h want 08000001aa", resp_out); end
        tick();
        vectors++;
        if ({ack_out, complete, idx_err, tmo_err} !== 4'b0100) begin
            miscompares++; $display("FAIL cmd8_done got %b want 0100", {ack_out, complete, idx_err, tmo_err});
        end
        tick();
        vectors++;
        if ({complete, busy} !== 2'b00) begin miscompares++; $display("FAIL cmd8_idle got %b want 00", {complete, busy}); end
    endtask

    task automatic test_timeout();
        int early;
        start_cmd(6'd17, 32'd0, 1'b0, 1'b0, 48'h510000000055);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        early = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (tmo_err || complete) early++;
        end
        tick();
        vectors++;
        if (tmo_err !== 1'b1 || early != 0) begin miscompares++; $display("FAIL tmo_at_64 got %b early %0d want 1 early 0", tmo_err, early); end
        vectors++;
        if (complete !== 1'b1 || resp_out !== 38'd0) begin
            miscompares++; $display("FAIL tmo_done complete %b resp %h want 1 0", complete, resp_out);
        end
        tick();
        vectors++;
        if ({busy, tmo_err} !== 2'b01) begin miscompares++; $display("FAIL tmo_hold got %b want 01", {busy, tmo_err}); end
    endtask

    task automatic test_index_error();
        int pulses;
        start_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 48'h48000001AA87);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        strobe_in = 1'b1; resp_in = {6'd5, 32'h1AA};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            strobe_in = 1'b0; resp_in = 38'd0;
            if (complete) pulses++;
        end
        vectors++;
        if (pulses != 1) begin miscompares++; $display("FAIL idxerr_pulses got %0d want 1", pulses); end
        vectors++;
        if ({idx_err, tmo_err} !== 2'b10) begin miscompares++; $display("FAIL idxerr_flags got %b want 10", {idx_err, tmo_err}); end
        vectors++;
        if (resp_out !== 38'h05000001AA) begin miscompares++; $display("FAIL idxerr_resp got %h want 05000001aa", resp_out); end
    endtask

    task automatic test_hold_and_retrigger();
        int unstable;
        int pulses;
        start_cmd(6'd17, 32'd0, 1'b1, 1'b1, 48'h510000000055);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            new_cmd = (i == 3) ? 1'b0 : 1'b1;
            tick();
            if (strobe_out !== 1'b1 || frame !== 48'h510000000055) unstable++;
        end
        vectors++;
        if (unstable != 0) begin miscompares++; $display("FAIL send_stable unstable cycles %0d want 0", unstable); end
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        pulses = complete ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (complete) pulses++;
        end
        vectors++;
        if (pulses != 1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL held_level pulses %0d busy %b want 1 0", pulses, busy);
        end
        new_cmd = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        start_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 48'h48000001AA87);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, strobe_out, ack_out, complete} !== 4'b0000 || frame !== 48'd0) begin
            miscompares++; $display("FAIL async_reset flags %b frame %h want 0000 0", {busy, strobe_out, ack_out, complete}, frame);
        end
        pulses = 0;
        tick();
        if (complete) pulses++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (complete) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL reset_no_complete got %0d want 0", pulses); end
        start_cmd(6'd0, 32'd0, 1'b1, 1'b0, 48'h400000000095);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        vectors++;
        if (complete !== 1'b1) begin miscompares++; $display("FAIL post_reset_complete got %b want 1", complete); end
        tick();
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_timeout();
        test_index_error();
        test_hold_and_retrigger();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
